alu_result_display: RTL and testbench
=====================================

ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is held during multiplexing (minimum 2).
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port res_valid  input  1  result-present strobe from the 6-bit add/subtract stage.
REQ-005 The block SHALL have port res_a, res_b  input  6 each  signed operands fed to the add/subtract stage.
REQ-006 The block SHALL have port res_sel  input  1  operation, 1 = subtract, 0 = add.
REQ-007 The block SHALL have port res_y  input  6  signed two's-complement result.
REQ-008 The block SHALL have port res_cout  input  1  carry out of the add/subtract stage.
REQ-009 The block SHALL have port res_ready  output  1  block accepts a capture this cycle.
REQ-010 The block SHALL have ports flag_zero, flag_neg, flag_ovf, flag_cout  output  1 each  registered result flags.
REQ-011 The block SHALL have port an  output  4  active-low digit enables, an[3] leftmost.
REQ-012 The block SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.

Function
REQ-013 The block SHALL implement states IDLE, CONVERT, DISPLAY; res_ready = 1 in IDLE and DISPLAY, 0 in CONVERT.
REQ-014 On an edge with res_valid && res_ready, the block SHALL capture res_a/res_b/res_sel/res_y/res_cout, go to CONVERT, and update all flags on that edge.
REQ-015 Flags SHALL be: zero = (y==0); neg = y[5]; cout = res_cout; ovf = add: a[5]==b[5] && y[5]!=a[5], subtract: a[5]!=b[5] && y[5]!=a[5].
REQ-016 CONVERT SHALL run sequential double-dabble on the 6-bit unsigned magnitude |y| (|-32| = 32), one bit per cycle, exactly 6 cycles, then go to DISPLAY.
REQ-017 Displayed digits SHALL be held in separate registers updated only on the CONVERT->DISPLAY edge; during CONVERT the previous digits remain shown.
REQ-018 Digit layout SHALL be an[3] sign ('-' = 7'b0111111 if neg, else blank), an[2] blank, an[1] tens (blank if 0), an[0] ones.
REQ-019 In IDLE all digits SHALL be blank (seg = 7'b1111111) while the scan continues.
REQ-020 A free-running refresh counter SHALL select digit 0,1,2,3 in turn for REFRESH_DIV cycles each, wrapping 3->0; exactly one an bit low at any time outside reset.
REQ-021 seg and an SHALL be registered and change together on the digit-advance edge.
REQ-022 res_valid while res_ready = 0 SHALL be ignored with no state change; a capture in DISPLAY SHALL restart CONVERT.
REQ-023 Digit glyphs 0-9 SHALL use standard encoding (0 = 7'b1000000, 5 = 7'b0010010).

Reset
REQ-024 With rst high at an edge the block SHALL go to IDLE, clear all flags, digit registers and refresh counter, set res_ready = 1, an = 4'b1111, seg = 7'b1111111.
REQ-025 Reset during CONVERT SHALL abort conversion with no digit update; the first digit enable asserts REFRESH_DIV cycles after rst falls.

Configuration
REQ-026 Macro ALU_OVF_DISPLAY_EN defined: a result with flag_ovf = 1 SHALL display blank,'O'(7'b1000000),'F'(7'b0001110),blank instead of the value, still after the 6-cycle CONVERT.
REQ-027 Macro ALU_OVF_DISPLAY_EN undefined: the wrapped two's-complement value SHALL be displayed; flag_ovf unaffected either way.

Verification (REFRESH_DIV = 4)
REQ-028 Reset: rst high 2 cycles -> an = 1111, seg = 1111111, flags 0, res_ready = 1.
REQ-029 Subtract: sel=1, a=30 (011110), b=15 (001111), y=15, cout=1 -> ready low 6 cycles, display blank,blank,'1','5'; neg=0, ovf=0, cout=1.
REQ-030 Subtract: sel=1, a=-20 (101100), b=-15 (110001), y=-5 (111011), cout=0 -> '-',blank,blank,'5'; neg=1, zero=0, ovf=0.
REQ-031 Add: sel=0, a=31, b=1, y=100000 -> ovf=1, neg=1; without macro '-',blank,'3','2'; with macro blank,'O','F',blank.
REQ-032 res_valid held high through CONVERT with changing res_y -> only first value captured; second capture occurs on first DISPLAY cycle.
REQ-033 rst pulse at CONVERT cycle 3 -> IDLE, all blank, flags 0, no stale digits afterwards.

Source files
------------

// File: rtl/alu_result_display.sv
// Flag register, serial double-dabble and 4-digit multiplexed display for the 6-bit add/sub result.
// Optional ALU_OVF_DISPLAY_EN shows "OF" instead of the wrapped value on overflow.
module alu_result_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [5:0] res_a,
    input  logic [5:0] res_b,
    input  logic       res_sel,
    input  logic [5:0] res_y,
    input  logic       res_cout,
    output logic       res_ready,
    output logic       flag_zero,
    output logic       flag_neg,
    output logic       flag_ovf,
    output logic       flag_cout,
    output logic [3:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {IDLE, CONVERT, DISPLAY} state_t;

    localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    state_t state, state_nx;

    logic          capture;
    logic          conv_done;
    logic          ovf_nx;
    logic [5:0]    mag;
    logic [5:0]    bin;
    logic [2:0]    bitcnt;
    logic [7:0]    bcd, bcd_adj, bcd_nx;
    logic [3:0]    d_tens, d_ones;
    logic          d_neg, d_valid;
    logic [DW-1:0] div_cnt;
    logic [1:0]    digit;
    logic [6:0]    glyph_sel;
`ifdef ALU_OVF_DISPLAY_EN
    logic          d_ovf;
`endif

    assign res_ready = (state != CONVERT);
    assign capture   = res_valid && res_ready;
    assign conv_done = (state == CONVERT) && (bitcnt == 3'd5);
    assign mag       = res_y[5] ? (~res_y + 6'd1) : res_y;

    always_comb begin
        ovf_nx = 1'b0;
        if (res_sel)
            ovf_nx = (res_a[5] != res_b[5]) && (res_y[5] != res_a[5]);
        else
            ovf_nx = (res_a[5] == res_b[5]) && (res_y[5] != res_a[5]);
    end

    // add-3 on any BCD nibble >= 5 before shifting in the next binary bit
    always_comb begin
        bcd_adj = bcd;
        if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
        bcd_nx = {bcd_adj[6:0], bin[5]};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (capture)   state_nx = CONVERT;
            CONVERT: if (conv_done) state_nx = DISPLAY;
            DISPLAY: if (capture)   state_nx = CONVERT;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
            flag_ovf  <= 1'b0;
            flag_cout <= 1'b0;
            bin       <= '0;
            bcd       <= '0;
            bitcnt    <= '0;
            d_tens    <= '0;
            d_ones    <= '0;
            d_neg     <= 1'b0;
            d_valid   <= 1'b0;
`ifdef ALU_OVF_DISPLAY_EN
            d_ovf     <= 1'b0;
`endif
        end else if (capture) begin
            flag_zero <= (res_y == 6'd0);
            flag_neg  <= res_y[5];
            flag_ovf  <= ovf_nx;
            flag_cout <= res_cout;
            bin       <= mag;
            bcd       <= '0;
            bitcnt    <= '0;
        end else if (state == CONVERT) begin
            bin    <= {bin[4:0], 1'b0};
            bcd    <= bcd_nx;
            bitcnt <= bitcnt + 3'd1;
            // flags are stable through CONVERT, so they describe this result
            if (conv_done) begin
                d_tens  <= bcd_nx[7:4];
                d_ones  <= bcd_nx[3:0];
                d_neg   <= flag_neg;
                d_valid <= 1'b1;
`ifdef ALU_OVF_DISPLAY_EN
                d_ovf   <= flag_ovf;
`endif
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = BLANK;
        endcase
        return g;
    endfunction

    always_comb begin
        glyph_sel = BLANK;
        if (d_valid) begin
            unique case (digit)
                2'd3:    glyph_sel = d_neg ? DASH : BLANK;
                2'd2:    glyph_sel = BLANK;
                2'd1:    glyph_sel = (d_tens == 4'd0) ? BLANK : glyph(d_tens);
                default: glyph_sel = glyph(d_ones);
            endcase
`ifdef ALU_OVF_DISPLAY_EN
            if (d_ovf) begin
                unique case (digit)
                    2'd2:    glyph_sel = 7'b1000000;
                    2'd1:    glyph_sel = 7'b0001110;
                    default: glyph_sel = BLANK;
                endcase
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= '0;
            an      <= 4'b1111;
            seg     <= BLANK;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
            an      <= ~(4'b0001 << digit);
            seg     <= glyph_sel;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed vector bench for alu_result_display with REFRESH_DIV = 4.
// Compile with ALU_OVF_DISPLAY_EN defined to check the overflow glyphs.
module tb_alu_result_display;

    localparam int RD = 4;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GO = 7'b1000000;
    localparam logic [6:0] GF = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst;
    logic       res_valid;
    logic [5:0] res_a, res_b, res_y;
    logic       res_sel, res_cout;
    logic       res_ready;
    logic       flag_zero, flag_neg, flag_ovf, flag_cout;
    logic [3:0] an;
    logic [6:0] seg;

    int n_chk = 0;
    int n_fail = 0;

    alu_result_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid),
        .res_a(res_a), .res_b(res_b),
        .res_sel(res_sel), .res_y(res_y),
        .res_cout(res_cout),
        .res_ready(res_ready),
        .flag_zero(flag_zero), .flag_neg(flag_neg),
        .flag_ovf(flag_ovf), .flag_cout(flag_cout),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sel;
        logic [5:0]  a, b, y;
        logic        cout;
        logic [3:0]  flags;
        logic [27:0] disp;
    } vec_t;

    vec_t tv[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_zero, flag_neg, flag_ovf, flag_cout};
    endfunction

    task automatic scan(output logic [27:0] d, output logic ok);
        d  = 'x;
        ok = 1'b1;
        for (int i = 0; i < 4 * RD; i++) begin
            @(negedge clk);
            case (an)
                4'b0111: d[27:21] = seg;
                4'b1011: d[20:14] = seg;
                4'b1101: d[13:7]  = seg;
                4'b1110: d[6:0]   = seg;
                default: ok = 1'b0;
            endcase
        end
    endtask

    task automatic drive(input vec_t v);
        res_sel  = v.sel;
        res_a    = v.a;
        res_b    = v.b;
        res_y    = v.y;
        res_cout = v.cout;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!res_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({name, " ready-low cycles"}, n, 6);
    endtask

    task automatic check_disp(input string name, input logic [27:0] exp);
        logic [27:0] d;
        logic        ok;
        repeat (4 * RD) @(negedge clk);
        scan(d, ok);
        check({name, " display"}, d, exp);
        check({name, " one-hot an"}, ok, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v);
        check({v.name, " ready before"}, res_ready, 1'b1);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        check({v.name, " flags"}, flags_now(), v.flags);
        wait_ready(v.name);
        check_disp(v.name, v.disp);
    endtask

    initial begin
        logic [27:0] d;
        logic        ok;

        tv[0] = '{"sub30-15", 1'b1, 6'b011110, 6'b001111, 6'b001111, 1'b1,
                  4'b0001, {BL, BL, G1, G5}};
        tv[1] = '{"sub-20+15", 1'b1, 6'b101100, 6'b110001, 6'b111011, 1'b0,
                  4'b0100, {DS, BL, BL, G5}};
`ifdef ALU_OVF_DISPLAY_EN
        tv[2] = '{"add31+1", 1'b0, 6'b011111, 6'b000001, 6'b100000, 1'b0,
                  4'b0110, {BL, GO, GF, BL}};
`else
        tv[2] = '{"add31+1", 1'b0, 6'b011111, 6'b000001, 6'b100000, 1'b0,
                  4'b0110, {DS, BL, G3, G2}};
`endif
        tv[3] = '{"add5-5", 1'b0, 6'b000101, 6'b111011, 6'b000000, 1'b1,
                  4'b1001, {BL, BL, BL, G0}};
        tv[4] = '{"add-16-16", 1'b0, 6'b110000, 6'b110000, 6'b100000, 1'b1,
                  4'b0101, {DS, BL, G3, G2}};
        tv[5] = '{"add4+5", 1'b0, 6'b000100, 6'b000101, 6'b001001, 1'b0,
                  4'b0000, {BL, BL, BL, G9}};

        rst = 1'b1;
        res_valid = 1'b0;
        drive(tv[5]);
        repeat (2) @(negedge clk);
        check("reset an", an, 4'b1111);
        check("reset seg", seg, BL);
        check("reset flags", flags_now(), 4'b0000);
        check("reset ready", res_ready, 1'b1);
        rst = 1'b0;
        repeat (RD - 1) @(negedge clk);
        check("an before first advance", an, 4'b1111);
        @(negedge clk);
        check("first digit enable", an, 4'b1110);
        check("idle seg blank", seg, BL);

        for (int i = 0; i < 6; i++) run_vec(tv[i]);

        // valid held high across CONVERT with changing inputs
        @(negedge clk);
        drive(tv[0]);
        res_valid = 1'b1;
        @(negedge clk);
        drive(tv[5]);
        check("hold flags unchanged", flags_now(), tv[0].flags);
        wait_ready("hold");
        @(negedge clk);
        check("hold second capture", res_ready, 1'b0);
        check("hold second flags", flags_now(), tv[5].flags);
        res_valid = 1'b0;
        wait_ready("hold2");
        check_disp("hold2", tv[5].disp);

        // reset in the middle of a conversion
        @(negedge clk);
        drive(tv[1]);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", res_ready, 1'b1);
        check("abort flags", flags_now(), 4'b0000);
        check("abort an", an, 4'b1111);
        check("abort seg", seg, BL);
        repeat (4 * RD) @(negedge clk);
        scan(d, ok);
        check("abort display", d, {BL, BL, BL, BL});
        check("abort one-hot an", ok, 1'b1);
        check("abort still idle", res_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
